// File: rtl/xgs_regif_pkg.sv
// Shared definitions for blocks that sit on the XGS register-file slave port.
package xgs_regif_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam int REG_DATA_W = 32;

  // Read data handed back when the slave never answers.
  localparam logic [REG_DATA_W-1:0] DEFAULT_POISON = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request found after last_grant, with wrap.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  logic [IDX_W-1:0] probe_idx;

  // Scan N positions starting one past the previous winner; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    probe_idx = '0;
    for (int i = 1; i <= N; i++) begin
      probe_idx = IDX_W'((int'(last_grant) + i) % N);
      if (!valid && req[probe_idx]) begin
        valid            = 1'b1;
        grant_idx        = probe_idx;
        grant[probe_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Shares the register-file slave port between N_MASTERS requesters, one
// transaction at a time, with round-robin grant and a read timeout that
// returns POISON instead of hanging the requester.
module reg_access_arbiter
  import xgs_regif_pkg::*;
#(
  parameter int                    N_MASTERS = 3,
  parameter int                    ADDR_W    = 11,
  parameter int                    TIMEOUT   = 64,
  parameter logic [REG_DATA_W-1:0] POISON    = DEFAULT_POISON
) (
  input  logic                              sys_clk,
  input  logic                              sys_reset_n,
  input  logic [N_MASTERS-1:0]              m_req,
  input  logic [N_MASTERS-1:0]              m_wr,
  input  logic [N_MASTERS*ADDR_W-1:0]       m_addr,
  input  logic [N_MASTERS*REG_DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*4-1:0]            m_be,
  output logic [N_MASTERS-1:0]              m_ack,
  output logic [REG_DATA_W-1:0]             m_rdata,
  output logic                              m_err,
  output logic                              reg_write,
  output logic                              reg_read,
  output logic [ADDR_W-1:0]                 reg_addr,
  output logic [REG_DATA_W-1:0]             reg_writedata,
  output logic [3:0]                        reg_beN,
  input  logic                              reg_readdatavalid,
  input  logic [REG_DATA_W-1:0]             reg_readdata,
  output logic                              busy,
  output logic [15:0]                       timeout_cnt
);

  localparam int               IDX_W     = $clog2(N_MASTERS);
  localparam int               CNT_W     = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  // Per-master views of the flattened request buses.
  logic [ADDR_W-1:0]     addr_arr  [N_MASTERS];
  logic [REG_DATA_W-1:0] wdata_arr [N_MASTERS];
  logic [3:0]            be_arr    [N_MASTERS];

  for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
    assign addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = m_wdata[gi*REG_DATA_W +: REG_DATA_W];
    assign be_arr[gi]    = m_be[gi*4 +: 4];
  end

  arb_state_t            state_q;
  logic [IDX_W-1:0]      last_grant_q;
  logic [N_MASTERS-1:0]  grant_oh_q;
  logic                  wr_q;
  logic                  reg_write_q;
  logic                  reg_read_q;
  logic [ADDR_W-1:0]     reg_addr_q;
  logic [REG_DATA_W-1:0] reg_wdata_q;
  logic [3:0]            reg_be_n_q;
  logic [CNT_W-1:0]      wait_cnt_q;
  logic [N_MASTERS-1:0]  ack_q;
  logic [REG_DATA_W-1:0] rdata_q;
  logic                  err_q;
  logic [15:0]           timeout_cnt_q;

  logic [N_MASTERS-1:0]  arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_valid;

  rr_arbiter #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (m_req),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .valid      (arb_valid)
  );

  // Transaction FSM; strobes and ack are single-cycle registered pulses,
  // while the holding registers double as the slave address/data/byte-enable outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      state_q       <= IDLE;
      last_grant_q  <= IDX_W'(N_MASTERS - 1);
      grant_oh_q    <= '0;
      wr_q          <= 1'b0;
      reg_write_q   <= 1'b0;
      reg_read_q    <= 1'b0;
      reg_addr_q    <= '0;
      reg_wdata_q   <= '0;
      reg_be_n_q    <= 4'hF;
      wait_cnt_q    <= '0;
      ack_q         <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      timeout_cnt_q <= '0;
    end else begin
      reg_write_q <= 1'b0;
      reg_read_q  <= 1'b0;
      ack_q       <= '0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            grant_oh_q   <= arb_grant;
            last_grant_q <= arb_idx;
            wr_q         <= m_wr[arb_idx];
            reg_addr_q   <= addr_arr[arb_idx];
            reg_wdata_q  <= wdata_arr[arb_idx];
            reg_be_n_q   <= ~be_arr[arb_idx];
            reg_write_q  <= m_wr[arb_idx];
            reg_read_q   <= ~m_wr[arb_idx];
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (wr_q) begin
            ack_q   <= grant_oh_q;
            rdata_q <= '0;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else begin
            wait_cnt_q <= '0;
            state_q    <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          // Real data beats the timeout when both land in the same cycle.
          if (reg_readdatavalid) begin
            ack_q   <= grant_oh_q;
            rdata_q <= reg_readdata;
            err_q   <= 1'b0;
            state_q <= RESP;
          end else if (wait_cnt_q == WAIT_LAST) begin
            ack_q   <= grant_oh_q;
            rdata_q <= POISON;
            err_q   <= 1'b1;
            if (timeout_cnt_q != 16'hFFFF) begin
              timeout_cnt_q <= timeout_cnt_q + 16'd1;
            end
            state_q <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_ack         = ack_q;
  assign m_rdata       = rdata_q;
  assign m_err         = err_q;
  assign reg_write     = reg_write_q;
  assign reg_read      = reg_read_q;
  assign reg_addr      = reg_addr_q;
  assign reg_writedata = reg_wdata_q;
  assign reg_beN       = reg_be_n_q;
  assign busy          = (state_q != IDLE);
  assign timeout_cnt   = timeout_cnt_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Self-checking bench for reg_access_arbiter: expected completions are queued
// when a request is driven and compared when the matching m_ack appears.
module tb_reg_access_arbiter;

  localparam int          N        = 3;
  localparam int          AW       = 11;
  localparam int          TO       = 64;
  localparam logic [31:0] POISON_V = 32'hDEAD_BEEF;

  logic            sys_clk = 1'b0;
  logic            sys_reset_n = 1'b0;
  logic [N-1:0]    m_req = '0;
  logic [N-1:0]    m_wr = '0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*32-1:0] m_wdata = '0;
  logic [N*4-1:0]  m_be = '0;
  logic [N-1:0]    m_ack;
  logic [31:0]     m_rdata;
  logic            m_err;
  logic            reg_write;
  logic            reg_read;
  logic [AW-1:0]   reg_addr;
  logic [31:0]     reg_writedata;
  logic [3:0]      reg_beN;
  logic            reg_readdatavalid = 1'b0;
  logic [31:0]     reg_readdata = '0;
  logic            busy;
  logic [15:0]     timeout_cnt;

  always #5 sys_clk = ~sys_clk;

  reg_access_arbiter #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .TIMEOUT   (TO),
    .POISON    (POISON_V)
  ) dut (
    .sys_clk           (sys_clk),
    .sys_reset_n       (sys_reset_n),
    .m_req             (m_req),
    .m_wr              (m_wr),
    .m_addr            (m_addr),
    .m_wdata           (m_wdata),
    .m_be              (m_be),
    .m_ack             (m_ack),
    .m_rdata           (m_rdata),
    .m_err             (m_err),
    .reg_write         (reg_write),
    .reg_read          (reg_read),
    .reg_addr          (reg_addr),
    .reg_writedata     (reg_writedata),
    .reg_beN           (reg_beN),
    .reg_readdatavalid (reg_readdatavalid),
    .reg_readdata      (reg_readdata),
    .busy              (busy),
    .timeout_cnt       (timeout_cnt)
  );

  typedef struct {
    int          master;
    logic [AW-1:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int acks_seen = 0;
  int ack_total = 0;
  int multi_ack = 0;
  int both_strobe = 0;
  int b2b_strobe = 0;
  logic prev_strobe = 1'b0;

  // Background protocol monitor; its counters are compared in test_protocol.
  always @(negedge sys_clk) begin
    if (|m_ack) ack_total++;
    if ($countones(m_ack) > 1) multi_ack++;
    if (reg_read && reg_write) both_strobe++;
    if ((reg_read || reg_write) && prev_strobe) b2b_strobe++;
    prev_strobe = reg_read || reg_write;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input int m, input logic [AW-1:0] a, input logic [31:0] w,
                              input logic [31:0] r, input logic e);
    exp_t x;
    x.master = m;
    x.addr   = a;
    x.wdata  = w;
    x.rdata  = r;
    x.err    = e;
    return x;
  endfunction

  function automatic logic [N-1:0] onehot(input int m);
    logic [N-1:0] v;
    v = '0;
    v[m] = 1'b1;
    return v;
  endfunction

  task automatic set_master(input int i, input logic wr, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic [3:0] be);
    m_req[i]            = 1'b1;
    m_wr[i]             = wr;
    m_addr[i*AW +: AW]  = a;
    m_wdata[i*32 +: 32] = d;
    m_be[i*4 +: 4]      = be;
  endtask

  task automatic wait_ack(input int budget, output int cycles, output bit got);
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(negedge sys_clk);
      cycles++;
      if (|m_ack) got = 1'b1;
    end
    if (got) acks_seen++;
  endtask

  task automatic wait_strobe(input int budget, output int cycles, output bit got);
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(negedge sys_clk);
      cycles++;
      if (reg_read || reg_write) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    sys_reset_n = 1'b0;
    m_req = '0;
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if ({m_ack, m_rdata, m_err} !== {3'b000, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_resp: got ack=%b rdata=%h err=%b want 000/0/0", m_ack, m_rdata, m_err);
    end
    n_cmp++;
    if ({reg_write, reg_read, reg_addr, reg_writedata} !== {1'b0, 1'b0, 11'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_slave: got wr=%b rd=%b addr=%h wdata=%h want all 0",
               reg_write, reg_read, reg_addr, reg_writedata);
    end
    n_cmp++;
    if (reg_beN !== 4'hF) begin
      n_bad++;
      $display("FAIL reset_beN: got %h want f", reg_beN);
    end
    n_cmp++;
    if ({busy, timeout_cnt} !== {1'b0, 16'h0}) begin
      n_bad++;
      $display("FAIL reset_status: got busy=%b tcnt=%h want 0/0", busy, timeout_cnt);
    end
    sys_reset_n = 1'b1;
    @(negedge sys_clk);
    $display("txn reset: done");
  endtask

  task automatic test_single_write();
    int   cyc;
    bit   got;
    exp_t e;
    exp_q.push_back(mk(1, 11'h040, 32'h1234_5678, 32'h0, 1'b0));
    set_master(1, 1'b1, 11'h040, 32'h1234_5678, 4'hF);
    @(negedge sys_clk);
    n_cmp++;
    if ({reg_write, reg_read, reg_addr, reg_writedata, reg_beN} !==
        {1'b1, 1'b0, 11'h040, 32'h1234_5678, 4'h0}) begin
      n_bad++;
      $display("FAIL write_strobe: got wr=%b rd=%b addr=%h wdata=%h beN=%h want 1/0/040/12345678/0",
               reg_write, reg_read, reg_addr, reg_writedata, reg_beN);
    end
    wait_ack(6, cyc, got);
    n_cmp++;
    if (!got || cyc != 1) begin
      n_bad++;
      $display("FAIL write_latency: got ack=%b after %0d cycles want ack after 1", got, cyc);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({m_ack, m_rdata, m_err, reg_write} !== {onehot(e.master), e.rdata, e.err, 1'b0}) begin
      n_bad++;
      $display("FAIL write_resp: got ack=%b rdata=%h err=%b wr=%b want %b/%h/%b/0",
               m_ack, m_rdata, m_err, reg_write, onehot(e.master), e.rdata, e.err);
    end
    m_req[1] = 1'b0;
    @(negedge sys_clk);
    n_cmp++;
    if ({m_ack, busy} !== {3'b000, 1'b0}) begin
      n_bad++;
      $display("FAIL write_after: got ack=%b busy=%b want 000/0", m_ack, busy);
    end
    $display("txn write m1 addr=040 data=12345678 ack_cycles=%0d", cyc);
  endtask

  task automatic test_single_read();
    exp_t e;
    exp_q.push_back(mk(0, 11'h010, 32'h0, 32'hCAFE_0001, 1'b0));
    set_master(0, 1'b0, 11'h010, 32'h0, 4'h3);
    reg_readdata = 32'h5555_5555;
    @(negedge sys_clk);
    n_cmp++;
    if ({reg_read, reg_write, reg_addr, reg_beN} !== {1'b1, 1'b0, 11'h010, 4'hC}) begin
      n_bad++;
      $display("FAIL read_strobe: got rd=%b wr=%b addr=%h beN=%h want 1/0/010/c",
               reg_read, reg_write, reg_addr, reg_beN);
    end
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if ({busy, m_ack, reg_read} !== {1'b1, 3'b000, 1'b0}) begin
      n_bad++;
      $display("FAIL read_wait: got busy=%b ack=%b rd=%b want 1/000/0", busy, m_ack, reg_read);
    end
    reg_readdatavalid = 1'b1;
    reg_readdata      = 32'hCAFE_0001;
    @(negedge sys_clk);
    reg_readdatavalid = 1'b0;
    reg_readdata      = 32'h5555_5555;
    if (|m_ack) acks_seen++;
    e = exp_q.pop_front();
    n_cmp++;
    if ({m_ack, m_rdata, m_err} !== {onehot(e.master), e.rdata, e.err}) begin
      n_bad++;
      $display("FAIL read_resp: got ack=%b rdata=%h err=%b want %b/%h/%b",
               m_ack, m_rdata, m_err, onehot(e.master), e.rdata, e.err);
    end
    m_req[0] = 1'b0;
    @(negedge sys_clk);
    n_cmp++;
    if ({m_ack, m_rdata} !== {3'b000, 32'hCAFE_0001}) begin
      n_bad++;
      $display("FAIL read_hold: got ack=%b rdata=%h want 000/cafe0001", m_ack, m_rdata);
    end
    $display("txn read m0 addr=010 k=3 rdata=%h err=%b", e.rdata, e.err);
  endtask

  task automatic test_back_to_back();
    int   cyc;
    bit   got;
    exp_t e;
    sys_reset_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_reset_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      exp_q.push_back(mk(n % N, AW'(11'h100 + (n % N)), 32'hA0A0_0000 + 32'(n % N), 32'h0, 1'b0));
    end
    for (int i = 0; i < N; i++) begin
      set_master(i, 1'b1, AW'(11'h100 + i), 32'hA0A0_0000 + 32'(i), 4'hF);
    end
    for (int n = 0; n < 6; n++) begin
      wait_strobe(6, cyc, got);
      n_cmp++;
      if (!got || reg_write !== 1'b1 || reg_addr !== exp_q[0].addr ||
          reg_writedata !== exp_q[0].wdata) begin
        n_bad++;
        $display("FAIL rr_strobe[%0d]: got strobe=%b wr=%b addr=%h wdata=%h want 1/1/%h/%h",
                 n, got, reg_write, reg_addr, reg_writedata, exp_q[0].addr, exp_q[0].wdata);
      end
      wait_ack(4, cyc, got);
      if (n == 5) m_req = '0;
      e = exp_q.pop_front();
      n_cmp++;
      if (!got || cyc != 1 || m_ack !== onehot(e.master) || m_err !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_ack[%0d]: got ack=%b cycles=%0d err=%b want %b after 1, err 0",
                 n, m_ack, cyc, m_err, onehot(e.master));
      end
      $display("txn rr n=%0d master=%0d ack=%b", n, e.master, m_ack);
    end
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if ({busy, m_ack} !== {1'b0, 3'b000}) begin
      n_bad++;
      $display("FAIL rr_idle: got busy=%b ack=%b want 0/000", busy, m_ack);
    end
  endtask

  task automatic test_timeout();
    int   cyc;
    bit   got;
    int   extra;
    exp_t e;
    exp_q.push_back(mk(2, 11'h7FC, 32'h0, POISON_V, 1'b1));
    set_master(2, 1'b0, 11'h7FC, 32'h0, 4'hF);
    wait_strobe(6, cyc, got);
    n_cmp++;
    if (!got || reg_read !== 1'b1 || reg_addr !== 11'h7FC) begin
      n_bad++;
      $display("FAIL to_strobe: got strobe=%b rd=%b addr=%h want 1/1/7fc", got, reg_read, reg_addr);
    end
    wait_ack(TO + 10, cyc, got);
    n_cmp++;
    if (!got || cyc != TO + 1) begin
      n_bad++;
      $display("FAIL to_latency: got ack=%b after %0d cycles want ack after %0d", got, cyc, TO + 1);
    end
    m_req[2] = 1'b0;
    reg_readdatavalid = 1'b1;
    reg_readdata      = 32'h1111_1111;
    e = exp_q.pop_front();
    n_cmp++;
    if ({m_ack, m_rdata, m_err} !== {onehot(e.master), e.rdata, e.err}) begin
      n_bad++;
      $display("FAIL to_resp: got ack=%b rdata=%h err=%b want %b/%h/%b",
               m_ack, m_rdata, m_err, onehot(e.master), e.rdata, e.err);
    end
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge sys_clk);
      if (c == 1) reg_readdatavalid = 1'b0;
      if (|m_ack) begin
        extra++;
        acks_seen++;
      end
    end
    n_cmp++;
    if (extra != 0 || busy !== 1'b0 || m_rdata !== POISON_V) begin
      n_bad++;
      $display("FAIL to_late: got extra_acks=%0d busy=%b rdata=%h want 0/0/%h",
               extra, busy, m_rdata, POISON_V);
    end
    n_cmp++;
    if (timeout_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL to_count: got %0d want 1", timeout_cnt);
    end
    $display("txn timeout m2 addr=7fc rdata=%h err=%b tcnt=%0d", m_rdata, m_err, timeout_cnt);
  endtask

  task automatic test_timeout_boundary();
    int   cyc;
    bit   got;
    int   early;
    exp_t e;
    exp_q.push_back(mk(1, 11'h200, 32'h0, 32'h0BAD_F00D, 1'b0));
    set_master(1, 1'b0, 11'h200, 32'h0, 4'hF);
    wait_strobe(6, cyc, got);
    n_cmp++;
    if (!got || reg_read !== 1'b1) begin
      n_bad++;
      $display("FAIL edge_strobe: got strobe=%b rd=%b want 1/1", got, reg_read);
    end
    early = 0;
    for (int c = 0; c < TO; c++) begin
      @(negedge sys_clk);
      if (|m_ack) early++;
    end
    reg_readdatavalid = 1'b1;
    reg_readdata      = 32'h0BAD_F00D;
    n_cmp++;
    if (early != 0) begin
      n_bad++;
      $display("FAIL edge_early: got %0d early acks want 0", early);
    end
    @(negedge sys_clk);
    reg_readdatavalid = 1'b0;
    reg_readdata      = 32'h0;
    if (|m_ack) acks_seen++;
    m_req[1] = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if ({m_ack, m_rdata, m_err} !== {onehot(e.master), e.rdata, e.err}) begin
      n_bad++;
      $display("FAIL edge_resp: got ack=%b rdata=%h err=%b want %b/%h/%b",
               m_ack, m_rdata, m_err, onehot(e.master), e.rdata, e.err);
    end
    n_cmp++;
    if (timeout_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL edge_count: got %0d want 1", timeout_cnt);
    end
    @(negedge sys_clk);
    $display("txn boundary m1 k=%0d rdata=%h err=%b", TO, e.rdata, e.err);
  endtask

  task automatic test_reset_mid_read();
    int   cyc;
    bit   got;
    int   extra;
    exp_t e;
    exp_q.push_back(mk(1, 11'h300, 32'h0, 32'h0, 1'b0));
    set_master(1, 1'b0, 11'h300, 32'h0, 4'hF);
    wait_strobe(6, cyc, got);
    repeat (3) @(negedge sys_clk);
    sys_reset_n = 1'b0;
    exp_q.delete();
    @(negedge sys_clk);
    n_cmp++;
    if ({busy, reg_read, reg_write, m_ack} !== {1'b0, 1'b0, 1'b0, 3'b000}) begin
      n_bad++;
      $display("FAIL mid_reset: got busy=%b rd=%b wr=%b ack=%b want 0/0/0/000",
               busy, reg_read, reg_write, m_ack);
    end
    n_cmp++;
    if ({reg_beN, timeout_cnt} !== {4'hF, 16'h0}) begin
      n_bad++;
      $display("FAIL mid_reset_regs: got beN=%h tcnt=%h want f/0", reg_beN, timeout_cnt);
    end
    sys_reset_n = 1'b1;
    m_req = '0;
    reg_readdatavalid = 1'b1;
    reg_readdata      = 32'h7777_7777;
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk);
      if (c == 1) reg_readdatavalid = 1'b0;
      if (|m_ack) begin
        extra++;
        acks_seen++;
      end
    end
    n_cmp++;
    if (extra != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_noack: got extra_acks=%0d busy=%b want 0/0", extra, busy);
    end
    exp_q.push_back(mk(0, 11'h004, 32'h0000_00A0, 32'h0, 1'b0));
    exp_q.push_back(mk(2, 11'h008, 32'h0000_00A2, 32'h0, 1'b0));
    set_master(0, 1'b1, 11'h004, 32'h0000_00A0, 4'hF);
    set_master(2, 1'b1, 11'h008, 32'h0000_00A2, 4'hF);
    for (int n = 0; n < 2; n++) begin
      wait_ack(8, cyc, got);
      e = exp_q.pop_front();
      m_req[e.master] = 1'b0;
      n_cmp++;
      if (!got || m_ack !== onehot(e.master) || m_err !== 1'b0) begin
        n_bad++;
        $display("FAIL mid_regrant[%0d]: got ack=%b err=%b want %b/0", n, m_ack, m_err, onehot(e.master));
      end
      $display("txn post_reset n=%0d master=%0d ack=%b", n, e.master, m_ack);
    end
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (ack_total != acks_seen) begin
      n_bad++;
      $display("FAIL proto_ack_count: got %0d acks want %0d", ack_total, acks_seen);
    end
    n_cmp++;
    if (multi_ack != 0) begin
      n_bad++;
      $display("FAIL proto_multi_ack: got %0d want 0", multi_ack);
    end
    n_cmp++;
    if (both_strobe != 0) begin
      n_bad++;
      $display("FAIL proto_both_strobe: got %0d want 0", both_strobe);
    end
    n_cmp++;
    if (b2b_strobe != 0) begin
      n_bad++;
      $display("FAIL proto_b2b_strobe: got %0d want 0", b2b_strobe);
    end
    $display("txn protocol acks=%0d", ack_total);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid_read();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_access_arbiter.md
Name: reg_access_arbiter

Overview:
- Shares the single register-file slave port of the XGS controller between N_MASTERS requesters (host BAR, sensor sequencer, debug/validation master).
- Round-robin grant, one outstanding transaction at a time.
- Read timeout returns a poison value so a dead slave cannot hang a requester.
- Sits between the requester bridges and the register file; all traffic runs on sys_clk.

Parameters:
- N_MASTERS, 3, number of requesters (2..8).
- ADDR_W, 11, register byte-address width.
- TIMEOUT, 64, max cycles waiting for reg_readdatavalid (>=2).
- POISON, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- sys_clk  in  1  clock.
- sys_reset_n  in  1  synchronous, active-low reset.
- m_req  in  N_MASTERS  per-master request; held high until that master's ack.
- m_wr  in  N_MASTERS  1=write, 0=read.
- m_addr  in  N_MASTERS*ADDR_W  per-master address (master i at slice i).
- m_wdata  in  N_MASTERS*32  per-master write data.
- m_be  in  N_MASTERS*4  per-master byte enables.
- m_ack  out  N_MASTERS  one-cycle completion pulse per master.
- m_rdata  out  32  read data, valid with m_ack.
- m_err  out  1  timeout flag, valid with m_ack.
- reg_write  out  1  slave write strobe.
- reg_read  out  1  slave read strobe.
- reg_addr  out  ADDR_W  slave address.
- reg_writedata  out  32  slave write data.
- reg_beN  out  4  slave byte enables, active low.
- reg_readdatavalid  in  1  slave read-data valid.
- reg_readdata  in  32  slave read data.
- busy  out  1  high in any state other than IDLE.
- timeout_cnt  out  16  saturating count of timeouts.

Behaviour:
- Reset (sys_reset_n=0 at a sys_clk edge):
  - State goes to IDLE.
  - All outputs go to 0, except reg_beN=4'hF.
  - last_grant is set to N_MASTERS-1, so master 0 has top priority first.
  - timeout_cnt is cleared.
- Reset mid-transaction aborts the transaction with no ack; the requester must reissue.
- State machine, states IDLE, ISSUE, WAIT_RD, RESP:
  - IDLE: if any m_req bit is set, grant the first requester found scanning from last_grant+1 with wrap. Latch its addr, wdata, be and wr into holding registers, update last_grant, go to ISSUE.
  - ISSUE: exactly one cycle; assert reg_write or reg_read with the latched fields.
    - Write: go to RESP.
    - Read: clear the wait counter, go to WAIT_RD.
  - WAIT_RD: a read strobe never coincides with readdatavalid; the earliest readdatavalid is the cycle after ISSUE.
    - If reg_readdatavalid=1: latch reg_readdata, err=0, go to RESP.
    - Else, when the wait counter reaches TIMEOUT-1: data=POISON, err=1, increment timeout_cnt (saturating at 16'hFFFF), go to RESP.
    - If readdatavalid arrives in the same cycle the counter hits TIMEOUT-1, real data wins and err=0.
  - RESP: pulse m_ack[grant] for one cycle, drive m_rdata and m_err, go to IDLE.
    - m_rdata=0 for writes.
    - m_rdata and m_err hold their values until the next RESP.
- Latency:
  - Write: request sampled in IDLE at cycle t, reg_write at t+1, m_ack at t+2.
  - Read: reg_read at t+1; readdatavalid at t+1+k (k>=1); m_ack at t+2+k.
- Requester rule: a master drops m_req on the edge after it sees m_ack. Because IDLE follows RESP, a master that keeps m_req high issues a new transaction and is scheduled by round-robin.
- A master that drops m_req before its ack keeps its slot; the transaction still completes.
- reg_readdatavalid outside WAIT_RD, including a late response after a timeout, is ignored.
- Strobes are never asserted outside ISSUE; reg_read and reg_write are never high together.
- Fairness: with all masters requesting continuously, grants rotate 0,1,...,N-1,0. No master waits more than N_MASTERS-1 transactions.

Decomposition:
- Shared package xgs_regif_pkg holds:
  - the state enum arb_state_t;
  - constant REG_DATA_W=32;
  - the default POISON value.
- One sub-module: rr_arbiter (parameter N; inputs req and last_grant; combinational one-hot grant plus index), reused by other shared-resource blocks.

Test Plan:
- Single write: m_req[1], addr 0x040, wdata 0x12345678, be 4'hF → reg_write exactly 1 cycle with reg_addr 0x040 and reg_beN 4'h0; m_ack[1] two cycles after req sampled; m_err=0.
- Single read, slave latency k=3, readdata 0xCAFE0001 → m_ack[0] at t+5 with m_rdata 0xCAFE0001, m_err=0.
- Contention: masters 0, 1, 2 request writes continuously from reset → grant order 0,1,2,0,1,2; no back-to-back strobes without an intervening RESP/IDLE.
- Timeout: read with slave silent, TIMEOUT=64 → m_ack 64 cycles after WAIT_RD entry, m_rdata 0xDEADBEEF, m_err=1, timeout_cnt 1. A late readdatavalid is ignored and causes no extra ack.
- Boundary: readdatavalid in the same cycle as the counter hits TIMEOUT-1 → real data, err=0, timeout_cnt unchanged.
- Reset mid-read (sys_reset_n low during WAIT_RD) → no m_ack, busy=0, strobes 0, next grant goes to master 0.
